// File: rtl/mcpu_pkg.sv
// Shared encodings for the multi-cycle CPU datapath and controller.
// PC-source selects, branch condition codes and the reset-PC default.
package mcpu_pkg;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_RS     = 2'b11;

  localparam logic [2:0] COND_NEVER  = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_NE     = 3'b010;
  localparam logic [2:0] COND_GEZ    = 3'b011;
  localparam logic [2:0] COND_GTZ    = 3'b100;
  localparam logic [2:0] COND_LEZ    = 3'b101;
  localparam logic [2:0] COND_LTZ    = 3'b110;
  localparam logic [2:0] COND_ALWAYS = 3'b111;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: condition code plus ALU zero/sign flags.
// Purely combinational so a pipelined datapath can reuse it.
module branch_cond
  import mcpu_pkg::*;
(
  input  logic [2:0] condition,
  input  logic       alu_zero,
  input  logic       alu_sign,
  output logic       cond_ok
);

  always_comb begin
    cond_ok = 1'b0;
    unique case (condition)
      COND_NEVER:  cond_ok = 1'b0;
      COND_EQ:     cond_ok = alu_zero;
      COND_NE:     cond_ok = !alu_zero;
      COND_GEZ:    cond_ok = !alu_sign;
      COND_GTZ:    cond_ok = !alu_sign && !alu_zero;
      COND_LEZ:    cond_ok = alu_sign || alu_zero;
      COND_LTZ:    cond_ok = alu_sign;
      COND_ALWAYS: cond_ok = 1'b1;
      default:     cond_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_ir_unit.sv
// Multi-cycle CPU front-end: PC, IR and ALUOut registers, next-PC
// selection, sticky misaligned-PC fault and performance counters.
module pc_ir_unit
  import mcpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          TAKEN_CNT_W = 16
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   PC_write,
  input  logic                   PC_write_cond,
  input  logic [2:0]             condition,
  input  logic [1:0]             PC_source,
  input  logic                   IR_write_en,
  input  logic                   Addreg_write_en,
  input  logic [31:0]            Mem_rdata,
  input  logic [31:0]            Alu_result,
  input  logic                   Alu_zero,
  input  logic                   Alu_sign,
  input  logic [31:0]            Rs_data,
  input  logic                   Fault_clr,
  output logic [31:0]            PC,
  output logic [31:0]            IR,
  output logic [31:0]            ALUOut,
  output logic                   Pc_fault,
  output logic [31:0]            Instr_cnt,
  output logic [TAKEN_CNT_W-1:0] Taken_cnt
);

  localparam logic [TAKEN_CNT_W-1:0] TCNT_ONE =
    {{(TAKEN_CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]            pc_q, pc_d;
  logic [31:0]            ir_q, ir_d;
  logic [31:0]            aluout_q, aluout_d;
  logic                   fault_q, fault_d;
  logic [31:0]            icnt_q, icnt_d;
  logic [TAKEN_CNT_W-1:0] tcnt_q, tcnt_d;

  logic        cond_ok;
  logic [31:0] cand;
  logic        aligned;
  logic        pc_we;

  branch_cond u_branch_cond (
    .condition (condition),
    .alu_zero  (Alu_zero),
    .alu_sign  (Alu_sign),
    .cond_ok   (cond_ok)
  );

  always_comb begin
    cand = Alu_result;
    unique case (PC_source)
      PC_SRC_ALU:    cand = Alu_result;
      PC_SRC_ALUOUT: cand = aluout_q;
      PC_SRC_JUMP:   cand = {pc_q[31:28], ir_q[25:0], 2'b00};
      PC_SRC_RS:     cand = Rs_data;
      default:       cand = Alu_result;
    endcase
  end

  assign aligned = (cand[1:0] == 2'b00);
  assign pc_we   = PC_write || (PC_write_cond && cond_ok);

  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    aluout_d = aluout_q;
    fault_d  = fault_q;
    icnt_d   = icnt_q;
    tcnt_d   = tcnt_q;

    // A misaligned target never reaches PC; clear loses to set.
    if (Fault_clr) fault_d = 1'b0;
    if (pc_we) begin
      if (aligned) pc_d = cand;
      else         fault_d = 1'b1;
    end

    if (IR_write_en) begin
      ir_d   = Mem_rdata;
      icnt_d = icnt_q + 32'd1;
    end

    if (Addreg_write_en) aluout_d = Alu_result;

    if (PC_write_cond && cond_ok && aligned && (tcnt_q != '1))
      tcnt_d = tcnt_q + TCNT_ONE;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      aluout_q <= '0;
      fault_q  <= 1'b0;
      icnt_q   <= '0;
      tcnt_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      aluout_q <= aluout_d;
      fault_q  <= fault_d;
      icnt_q   <= icnt_d;
      tcnt_q   <= tcnt_d;
    end
  end

  assign PC        = pc_q;
  assign IR        = ir_q;
  assign ALUOut    = aluout_q;
  assign Pc_fault  = fault_q;
  assign Instr_cnt = icnt_q;
  assign Taken_cnt = tcnt_q;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Scoreboard bench for pc_ir_unit: directed program-flow scenarios,
// randomized enables and a taken-counter saturation run.
module tb_pc_ir_unit;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        PC_write, PC_write_cond;
  logic [2:0]  condition;
  logic [1:0]  PC_source;
  logic        IR_write_en, Addreg_write_en;
  logic [31:0] Mem_rdata, Alu_result;
  logic        Alu_zero, Alu_sign;
  logic [31:0] Rs_data;
  logic        Fault_clr;
  logic [31:0] PC, IR, ALUOut;
  logic        Pc_fault;
  logic [31:0] Instr_cnt;
  logic [15:0] Taken_cnt;

  pc_ir_unit dut (
    .Clk             (Clk),
    .Rst_n           (Rst_n),
    .PC_write        (PC_write),
    .PC_write_cond   (PC_write_cond),
    .condition       (condition),
    .PC_source       (PC_source),
    .IR_write_en     (IR_write_en),
    .Addreg_write_en (Addreg_write_en),
    .Mem_rdata       (Mem_rdata),
    .Alu_result      (Alu_result),
    .Alu_zero        (Alu_zero),
    .Alu_sign        (Alu_sign),
    .Rs_data         (Rs_data),
    .Fault_clr       (Fault_clr),
    .PC              (PC),
    .IR              (IR),
    .ALUOut          (ALUOut),
    .Pc_fault        (Pc_fault),
    .Instr_cnt       (Instr_cnt),
    .Taken_cnt       (Taken_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] aluout;
    logic        fault;
    logic [31:0] icnt;
    int          tcnt;
  } exp_t;

  exp_t m;
  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: outputs are registered, so every clock (or reset) event
  // that the driver recorded gets compared against its expectation.
  initial begin
    forever begin
      @(negedge Clk or negedge Rst_n);
      #1;
      while (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("pc", PC, e.pc);
        chk("ir", IR, e.ir);
        chk("aluout", ALUOut, e.aluout);
        chk("fault", {31'd0, Pc_fault}, {31'd0, e.fault});
        chk("instr_cnt", Instr_cnt, e.icnt);
        chk("taken_cnt", {16'd0, Taken_cnt}, e.tcnt[31:0]);
      end
    end
  end

  function automatic exp_t reset_state();
    exp_t r;
    r.pc = 32'h0; r.ir = 32'h0; r.aluout = 32'h0;
    r.fault = 1'b0; r.icnt = 32'h0; r.tcnt = 0;
    return r;
  endfunction

  task automatic idle();
    PC_write = 0; PC_write_cond = 0; condition = 3'd0;
    PC_source = 2'd0; IR_write_en = 0; Addreg_write_en = 0;
    Mem_rdata = 32'h0; Rs_data = 32'h0; Fault_clr = 0;
    Alu_result = 32'h0; Alu_zero = 1; Alu_sign = 0;
  endtask

  task automatic set_alu(logic [31:0] v);
    Alu_result = v;
    Alu_zero = (v == 32'h0);
    Alu_sign = v[31];
  endtask

  // Reference: branch taken when the signed ALU value meets the test.
  function automatic bit cond_true(logic [2:0] c, logic [31:0] v);
    int sv;
    sv = $signed(v);
    case (c)
      3'd0: return 0;
      3'd1: return sv == 0;
      3'd2: return sv != 0;
      3'd3: return sv >= 0;
      3'd4: return sv > 0;
      3'd5: return sv <= 0;
      3'd6: return sv < 0;
      default: return 1;
    endcase
  endfunction

  task automatic step();
    exp_t n;
    logic [31:0] tgt;
    bit ok, we, ok_align;
    n = m;
    ok = cond_true(condition, Alu_result);
    case (PC_source)
      2'd0: tgt = Alu_result;
      2'd1: tgt = m.aluout;
      2'd2: tgt = (m.pc & 32'hF000_0000) | ((m.ir & 32'h03FF_FFFF) << 2);
      default: tgt = Rs_data;
    endcase
    ok_align = (tgt % 4) == 0;
    we = PC_write || (PC_write_cond && ok);
    if (Fault_clr) n.fault = 0;
    if (we && ok_align) n.pc = tgt;
    if (we && !ok_align) n.fault = 1;
    if (IR_write_en) begin
      n.ir = Mem_rdata;
      n.icnt = m.icnt + 1;
    end
    if (Addreg_write_en) n.aluout = Alu_result;
    if (PC_write_cond && ok && ok_align && m.tcnt < 65535)
      n.tcnt = m.tcnt + 1;
    @(posedge Clk);
    #1;
    m = n;
    q.push_back(n);
  endtask

  task automatic async_reset();
    @(negedge Clk);
    #2;
    Rst_n = 0;
    m = reset_state();
    q.push_back(m);
    #1;
    idle();
    @(posedge Clk);
    #2;
    Rst_n = 1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    Rst_n = 0;
    m = reset_state();
    @(posedge Clk);
    #1;
    q.push_back(m);
    @(posedge Clk);
    #2;
    Rst_n = 1;

    // Fetch
    idle();
    IR_write_en = 1; PC_write = 1; PC_source = 2'd0;
    Mem_rdata = 32'h0441_0003; set_alu(32'd4);
    step();
    // Decode computes branch target, then bgez taken
    idle(); Addreg_write_en = 1; set_alu(32'h10);
    step();
    idle(); PC_write_cond = 1; condition = 3'd3;
    PC_source = 2'd1; set_alu(32'h0);
    step();
    // Same branch with negative compare: not taken
    idle(); Addreg_write_en = 1; set_alu(32'h20);
    step();
    idle(); PC_write_cond = 1; condition = 3'd3;
    PC_source = 2'd1; set_alu(32'h8000_0000);
    step();
    // Jump
    idle(); PC_write = 1; set_alu(32'h4000_0008);
    IR_write_en = 1; Mem_rdata = 32'h0000_0040;
    step();
    idle(); PC_write = 1; PC_source = 2'd2;
    step();
    // Misaligned jr, set-over-clear, then clear
    idle(); PC_write = 1; PC_source = 2'd3; Rs_data = 32'h102;
    step();
    idle(); PC_write = 1; PC_source = 2'd3; Rs_data = 32'h103;
    Fault_clr = 1;
    step();
    idle(); Fault_clr = 1;
    step();
    // Both writes with condition false: PC moves, no taken count
    idle(); PC_write = 1; PC_write_cond = 1; condition = 3'd1;
    set_alu(32'h44);
    step();
    // Reset between edges while a branch is pending
    idle(); Addreg_write_en = 1; set_alu(32'h80);
    step();
    idle(); PC_write_cond = 1; condition = 3'd7; PC_source = 2'd1;
    async_reset();

    for (int i = 0; i < 400; i++) begin
      logic [31:0] v, r;
      idle();
      v = $urandom;
      if ($urandom_range(3) != 0) v[1:0] = 2'b00;
      if ($urandom_range(7) == 0) v = 32'h0;
      r = $urandom;
      if ($urandom_range(1) == 0) r[1:0] = 2'b00;
      set_alu(v);
      Rs_data = r;
      Mem_rdata = $urandom;
      condition = 3'($urandom_range(7));
      PC_source = 2'($urandom_range(3));
      PC_write = ($urandom_range(3) == 0);
      PC_write_cond = ($urandom_range(1) == 0);
      IR_write_en = ($urandom_range(2) == 0);
      Addreg_write_en = ($urandom_range(1) == 0);
      Fault_clr = ($urandom_range(5) == 0);
      step();
    end

    // Saturate the taken counter
    idle(); PC_write_cond = 1; condition = 3'd7;
    PC_source = 2'd0; set_alu(32'h100);
    while (m.tcnt < 65535) step();
    for (int i = 0; i < 3; i++) step();

    idle();
    @(negedge Clk);
    #3;
    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_ir_unit.md
# pc_ir_unit

Datapath front-end of the multi-cycle CPU: holds the PC, instruction register (IR) and ALU-result register (ALUOut). It evaluates branch conditions and forms the next PC. It consumes the controller's PC_write, PC_write_cond, condition, PC_source, IR_write_en and Addreg_write_en, and drives IR back to the controller. It also keeps a sticky misaligned-PC fault flag and two performance counters.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset.
- TAKEN_CNT_W, 16, width of the taken-branch counter.

- Clk  in  1  rising-edge clock.
- Rst_n  in  1  reset; one clock; asynchronous, active-low.
- PC_write  in  1  unconditional PC update.
- PC_write_cond  in  1  PC update only if the branch condition holds.
- condition  in  3  branch condition code.
- PC_source  in  2  next-PC select.
- IR_write_en  in  1  load IR from Mem_rdata.
- Addreg_write_en  in  1  load ALUOut from Alu_result.
- Mem_rdata  in  32  memory read data; valid in the fetch state.
- Alu_result  in  32  ALU output (combinational).
- Alu_zero  in  1  ALU result == 0.
- Alu_sign  in  1  ALU result bit 31.
- Rs_data  in  32  register-file A-port data, used for jr/jalr.
- Fault_clr  in  1  clears Pc_fault.
- PC  out  32  current PC.
- IR  out  32  instruction register.
- ALUOut  out  32  registered ALU result.
- Pc_fault  out  1  sticky misaligned-target flag.
- Instr_cnt  out  32  number of IR loads, wraps.
- Taken_cnt  out  TAKEN_CNT_W  number of taken conditional branches, saturating.

## Operation
- Next-PC candidate by PC_source:
  - 00: Alu_result (PC+4 during fetch).
  - 01: ALUOut (branch target computed in decode).
  - 10: {PC[31:28], IR[25:0], 2'b00}.
  - 11: Rs_data.
- Condition true (cond_ok) by condition code:
  - 000 never; 001 Alu_zero; 010 !Alu_zero; 011 !Alu_sign (≥0).
  - 100 !Alu_sign & !Alu_zero (>0); 101 Alu_sign | Alu_zero (≤0); 110 Alu_sign (<0); 111 always.
- pc_we = PC_write | (PC_write_cond & cond_ok).
- When pc_we is set:
  - Candidate[1:0] == 0: PC ← candidate.
  - Otherwise: PC holds and Pc_fault is set.
- Pc_fault is sticky. Fault_clr clears it. If a set and a clear occur in the same cycle, set wins.
- IR_write_en: IR ← Mem_rdata and Instr_cnt increments (wraps mod 2^32). A fault does not block an IR load.
- Addreg_write_en: ALUOut ← Alu_result.
- Taken_cnt increments when PC_write_cond & cond_ok & the candidate is aligned. It saturates at all-ones.
- PC_write and PC_write_cond both set: treated as an unconditional write; Taken_cnt increments only if cond_ok.
- Registers load independently; any combination of enables may be active in one cycle.

## Timing
- All state updates on the rising edge of Clk. No combinational path from inputs to outputs; every output is a register.
- Reset values: PC = RESET_PC, IR = 0, ALUOut = 0, Pc_fault = 0, Instr_cnt = 0, Taken_cnt = 0.
- Reset asserted mid-instruction: all registers take reset values immediately. The first fetch follows reset release.
- Fetch cycle (IR_write_en = PC_write = 1, PC_source = 00):
  - IR captures the word addressed by the old PC.
  - PC takes PC+4 at the same edge.
  - Both visible the next cycle.
- Branch latency: the new PC is visible one cycle after the PC_write_cond cycle.
- ALUOut written in decode holds until the next Addreg_write_en, so it is valid in the branch cycle.

## Structure
- Shared package mcpu_pkg holds:
  - PC_SRC_ALU/ALUOUT/JUMP/RS (2-bit).
  - COND_NEVER, COND_EQ, COND_NE, COND_GEZ, COND_GTZ, COND_LEZ, COND_LTZ, COND_ALWAYS (3-bit).
  - The reset-PC default.
- One sub-module, branch_cond: purely combinational; (condition, Alu_zero, Alu_sign) → cond_ok. It is shared with any future pipeline variant.
- All registers and counters live in pc_ir_unit.

## Test plan
- Reset, then a fetch with Mem_rdata = 32'h0441_0003, Alu_result = 4 → next cycle PC = 4, IR = 32'h0441_0003, Instr_cnt = 1.
- Decode with Addreg_write_en, Alu_result = 32'h0000_0010; then PC_write_cond, condition = 011, Alu_sign = 0, PC_source = 01 → PC = 32'h10, Taken_cnt = 1.
- Same sequence with Alu_sign = 1 → PC unchanged, Taken_cnt unchanged.
- Jump: PC = 32'h4000_0008, IR[25:0] = 26'h000_0040, PC_write, PC_source = 10 → PC = 32'h4000_0100.
- Jr with Rs_data = 32'h0000_0102 → PC holds, Pc_fault = 1. Fault_clr and a second misaligned write in the same cycle → Pc_fault stays 1. Fault_clr alone → 0.
- Async reset asserted between clock edges mid-branch → all outputs return to reset values without waiting for a clock edge. Taken_cnt driven to 16'hFFFF then one more taken branch → stays 16'hFFFF.
